// File: rtl/wave_seq_pkg.sv
// Shared types for the wave sequencer: generator shape codes, FSM states and the
// segment record stored in the program table.
package wave_seq_pkg;

    localparam int SEQ_PINC_W = 16;
    localparam int SEQ_DUR_W  = 16;

    typedef enum logic [1:0] {
        SHAPE_SINE     = 2'd0,
        SHAPE_SQUARE   = 2'd1,
        SHAPE_TRIANGLE = 2'd2,
        SHAPE_SAW      = 2'd3
    } shape_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        shape_e                shape;
        logic [SEQ_PINC_W-1:0] pinc;
        logic [SEQ_DUR_W-1:0]  dur;
    } seg_t;

endpackage

// File: rtl/wave_seq_table.sv
// Program table: NSEG segment records, one synchronous write port and one
// combinational read port. Entries clear to zero on reset.
module wave_seq_table
    import wave_seq_pkg::*;
#(
    parameter int NSEG = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_i,
    input  logic [$clog2(NSEG)-1:0] wr_addr_i,
    input  seg_t                    wr_seg_i,
    input  logic [$clog2(NSEG)-1:0] rd_addr_i,
    output seg_t                    rd_seg_o
);

    seg_t mem_q [NSEG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSEG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[wr_addr_i] <= wr_seg_i;
        end
    end

    assign rd_seg_o = mem_q[rd_addr_i];

endmodule

// File: rtl/wave_sequencer.sv
// Segment sequencer driving the wave generator's enable/shape/phase-increment with
// cycle-exact durations. WAVE_SEQ_LOOP_EN: replay the program until abort, no done.
module wave_sequencer
    import wave_seq_pkg::*;
#(
    parameter int NSEG   = 4,
    parameter int PINC_W = SEQ_PINC_W,
    parameter int DUR_W  = SEQ_DUR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [$clog2(NSEG)-1:0] cfg_addr,
    input  logic [1:0]              cfg_shape,
    input  logic [PINC_W-1:0]       cfg_pinc,
    input  logic [DUR_W-1:0]        cfg_dur,
    input  logic [$clog2(NSEG):0]   seg_count,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(NSEG)-1:0] seg_idx,
    output logic                    gen_en,
    output logic [1:0]              gen_shape,
    output logic [PINC_W-1:0]       gen_pinc,
    output logic                    gen_phase_rst
);

    localparam int AW = $clog2(NSEG);
    localparam int CW = AW + 1;

    state_e            state_q, state_d;
    logic [AW-1:0]     seg_idx_q, seg_idx_d;
    logic [AW-1:0]     last_q, last_d;
    logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              gen_en_q, gen_en_d;
    logic [1:0]        gen_shape_q, gen_shape_d;
    logic [PINC_W-1:0] gen_pinc_q, gen_pinc_d;
    logic              phase_rst_q, phase_rst_d;
    logic              load_seg, hold_seg;
    logic              tbl_we;
    seg_t              wr_seg, rd_seg;
    logic [DUR_W-1:0]  rd_dur;

    // The table is frozen while a program runs so a sequence is never altered mid-flight.
    assign tbl_we = cfg_we && (state_q == ST_IDLE || state_q == ST_DONE);
    assign wr_seg = '{shape: shape_e'(cfg_shape), pinc: SEQ_PINC_W'(cfg_pinc), dur: SEQ_DUR_W'(cfg_dur)};
    assign rd_dur = DUR_W'(rd_seg.dur);

    // Read at the next index so a new segment lands in the output registers with no gap.
    wave_seq_table #(.NSEG(NSEG)) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (tbl_we),
        .wr_addr_i (cfg_addr),
        .wr_seg_i  (wr_seg),
        .rd_addr_i (seg_idx_d),
        .rd_seg_o  (rd_seg)
    );

    always_comb begin
        state_d   = state_q;
        seg_idx_d = seg_idx_q;
        last_d    = last_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        load_seg  = 1'b0;
        hold_seg  = 1'b0;
        if (abort) begin
            state_d   = ST_IDLE;
            seg_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_LOAD;
                        busy_d    = 1'b1;
                        seg_idx_d = '0;
                        if (seg_count == '0)
                            last_d = '0;
                        else if (seg_count > CW'(NSEG))
                            last_d = AW'(NSEG - 1);
                        else
                            last_d = AW'(seg_count - CW'(1));
                    end
                end
                ST_LOAD: begin
                    state_d  = ST_RUN;
                    busy_d   = 1'b1;
                    load_seg = 1'b1;
                end
                ST_RUN: begin
                    busy_d = 1'b1;
                    if (dur_cnt_q != '0) begin
                        hold_seg = 1'b1;
                    end else if (seg_idx_q != last_q) begin
                        seg_idx_d = seg_idx_q + AW'(1);
                        load_seg  = 1'b1;
                    end else begin
`ifdef WAVE_SEQ_LOOP_EN
                        seg_idx_d = '0;
                        load_seg  = 1'b1;
`else
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dur_cnt_d   = '0;
        gen_en_d    = 1'b0;
        gen_shape_d = '0;
        gen_pinc_d  = '0;
        phase_rst_d = 1'b0;
        if (load_seg) begin
            gen_en_d    = 1'b1;
            gen_shape_d = rd_seg.shape;
            gen_pinc_d  = PINC_W'(rd_seg.pinc);
            phase_rst_d = 1'b1;
            dur_cnt_d   = (rd_dur == '0) ? '0 : rd_dur - DUR_W'(1);
        end else if (hold_seg) begin
            gen_en_d    = 1'b1;
            gen_shape_d = gen_shape_q;
            gen_pinc_d  = gen_pinc_q;
            dur_cnt_d   = dur_cnt_q - DUR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            seg_idx_q   <= '0;
            last_q      <= '0;
            dur_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gen_en_q    <= 1'b0;
            gen_shape_q <= '0;
            gen_pinc_q  <= '0;
            phase_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_idx_q   <= seg_idx_d;
            last_q      <= last_d;
            dur_cnt_q   <= dur_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            gen_en_q    <= gen_en_d;
            gen_shape_q <= gen_shape_d;
            gen_pinc_q  <= gen_pinc_d;
            phase_rst_q <= phase_rst_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign seg_idx       = seg_idx_q;
    assign gen_en        = gen_en_q;
    assign gen_shape     = gen_shape_q;
    assign gen_pinc      = gen_pinc_q;
    assign gen_phase_rst = phase_rst_q;

endmodule
